// File: rtl/expr_tt_sweeper.sv
// Exhaustive truth-table sweeper: walks vec_out_o over all 2^N_IN vectors, samples f_in_i
// after SETTLE_CYCLES, and compares against a golden table. Optional macro: TT_EARLY_ABORT_EN.
module expr_tt_sweeper #(
    parameter int N_IN          = 5,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [(1<<N_IN)-1:0]    expected_tt_i,
    output logic [N_IN-1:0]         vec_out_o,
    input  logic                    f_in_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    pass_o,
    output logic [(1<<N_IN)-1:0]    captured_tt_o,
    output logic [N_IN:0]           mismatch_count_o,
    output logic                    first_fail_valid_o,
    output logic [N_IN-1:0]         first_fail_idx_o
);
    localparam int NV    = 1 << N_IN;
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0]  IDX_LAST = '1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q;
    logic [NV-1:0]     exp_q;
    logic [NV-1:0]     cap_q;
    logic [N_IN:0]     mcnt_q;
    logic              ffv_q;
    logic [N_IN-1:0]   ffi_q;
    logic [N_IN-1:0]   idx_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;

    logic sample_d;
    logic mis_d;
    logic stop_d;

    assign sample_d = (state_q == RUN) && (cnt_q == CNT_LAST);
    assign mis_d    = f_in_i != exp_q[idx_q];
`ifdef TT_EARLY_ABORT_EN
    assign stop_d   = (idx_q == IDX_LAST) || mis_d;
`else
    assign stop_d   = (idx_q == IDX_LAST);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            exp_q   <= '0;
            cap_q   <= '0;
            mcnt_q  <= '0;
            ffv_q   <= 1'b0;
            ffi_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        exp_q   <= expected_tt_i;
                        cap_q   <= '0;
                        mcnt_q  <= '0;
                        ffv_q   <= 1'b0;
                        ffi_q   <= '0;
                        pass_q  <= 1'b0;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (!sample_d) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        cap_q[idx_q] <= f_in_i;
                        cnt_q        <= '0;
                        if (mis_d) begin
                            mcnt_q <= mcnt_q + 1'b1;
                            if (!ffv_q) begin
                                ffv_q <= 1'b1;
                                ffi_q <= idx_q;
                            end
                        end
                        // pass must account for the vector sampled on this very edge
                        if (stop_d) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (mcnt_q == '0) && !mis_d;
                            state_q <= DONE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // vec_out tracks idx directly so the driven vector and the sampled index never diverge
    assign vec_out_o          = idx_q;
    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign pass_o             = pass_q;
    assign captured_tt_o      = cap_q;
    assign mismatch_count_o   = mcnt_q;
    assign first_fail_valid_o = ffv_q;
    assign first_fail_idx_o   = ffi_q;
endmodule

// File: doc/expr_tt_sweeper.md
Name: expr_tt_sweeper

Overview:
- Exhaustive truth-table sweeper wrapped around one synthesized combinational expression netlist.
- Upstream side: drives every input vector onto the netlist inputs, in order from 0 to 2^N_IN-1.
- Downstream side: samples the netlist output after a settle window and assembles the captured truth table.
- Compares the captured table against a golden table and reports pass/fail, mismatch count and first failing index.
- Used as the in-silicon/sim equivalence check for generated netlists.

Parameters:
- N_IN, 5, number of netlist inputs; the sweep covers 2^N_IN vectors.
- SETTLE_CYCLES, 1, clock cycles each vector is held before f_in is sampled; legal values are >= 1.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  launches a sweep; honoured only in IDLE or DONE.
- expected_tt  input  2^N_IN  golden table; bit i = expected F for vector i; sampled once on the accepted start.
- vec_out  output  N_IN  vector driven to the netlist; bit N_IN-1 = first input (a), bit 0 = last input (e).
- f_in  input  1  netlist output F.
- busy  output  1  high while sweeping.
- done  output  1  high in DONE state.
- pass  output  1  valid when done=1; 1 means captured_tt == expected table.
- captured_tt  output  2^N_IN  captured F per vector.
- mismatch_count  output  N_IN+1  number of mismatching vectors.
- first_fail_valid  output  1  at least one mismatch seen.
- first_fail_idx  output  N_IN  index of the lowest mismatching vector.

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset: state=IDLE; vec_out=0; busy=0; done=0; pass=0; captured_tt=0; mismatch_count=0; first_fail_valid=0; first_fail_idx=0; internal idx=0; internal cnt=0.
- rst is asserted mid-sweep: same values on the next edge; the partial sweep is discarded and no done pulse is produced.
- IDLE/DONE + start=1:
  - latch expected_tt into exp_q.
  - clear captured_tt, mismatch_count, first_fail_*, pass.
  - set idx=0, vec_out=0, cnt=0, busy=1, done=0.
  - go to RUN.
- RUN, each cycle:
  - if cnt < SETTLE_CYCLES-1: cnt++.
  - else (sample edge): captured_tt[idx] <= f_in.
    - if f_in != exp_q[idx]: mismatch_count++; if first_fail_valid=0, set first_fail_idx=idx and first_fail_valid=1.
    - cnt=0.
    - if idx == 2^N_IN-1: go to DONE; busy=0; done=1; pass = (no mismatch over the whole sweep, including this vector).
    - else: idx++ and vec_out=idx+1, registered in the same edge.
- Timing:
  - each vector is stable on vec_out for exactly SETTLE_CYCLES cycles before its sample edge.
  - busy is high for exactly 2^N_IN*SETTLE_CYCLES cycles.
  - done rises on the edge after the last sample, with outputs already final.
- DONE: all results, and vec_out (last vector), hold until start or rst.
- start during RUN: ignored; no restart, no effect on exp_q.
- Changes to expected_tt after the accepted start: no effect.
- mismatch_count width N_IN+1: holds the full 2^N_IN without wrap.
- f_in is assumed to be a combinational function of vec_out only; no synchronization is performed.

Optional Feature:
- Macro: TT_EARLY_ABORT_EN.
- Defined:
  - at the sample edge of the first mismatch, go straight to DONE with pass=0, busy=0, done=1.
  - mismatch_count=1, first_fail_idx=that index.
  - captured_tt holds bits 0..idx only; higher bits stay 0.
  - vec_out holds the failing vector.
- Undefined: the full sweep always runs; there is no abort logic.

Test Plan:
- Full-sweep pass:
  - stimulus: N_IN=5, SETTLE_CYCLES=1, f_in = vec_out[4]&vec_out[3], expected_tt=32'hFF000000, pulse start.
  - response: busy high 32 cycles; done=1; pass=1; captured_tt=32'hFF000000; mismatch_count=0; first_fail_valid=0.
- Multiple mismatches:
  - stimulus: same f_in, expected_tt=32'h7F000003.
  - response: pass=0; mismatch_count=3; first_fail_valid=1; first_fail_idx=0; captured_tt=32'hFF000000.
- Settle timing:
  - stimulus: SETTLE_CYCLES=3, f_in tied 1, expected_tt=32'hFFFFFFFF.
  - response: busy high exactly 96 cycles; each vec_out value is held 3 cycles; pass=1.
- Reset mid-operation and start-while-busy:
  - stimulus: pulse start again at cycle 10 of a sweep; then assert rst at cycle 20.
  - response: the second start has no effect; after rst all outputs equal their reset values; a new start runs a clean sweep to pass.
- Early abort (TT_EARLY_ABORT_EN defined):
  - stimulus: f_in = vec_out[4]&vec_out[3], expected_tt=32'hFF000020.
  - response: DONE after the sample of idx 5 (6 cycles busy); pass=0; mismatch_count=1; first_fail_idx=5; captured_tt=0.
- Back-to-back restart:
  - stimulus: start in DONE with a new expected_tt.
  - response: previous results are cleared on the start edge; the new sweep completes and results reflect only the new table.
